// File: rtl/rpn_evaluator.sv
// rpn_evaluator: evaluates a postfix token queue on an operand stack with a multicycle signed divider
module rpn_evaluator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       queue_token,
  output logic             rd_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       err_code
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DIVIDE, DIVWB} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [SW-1:0] sp;
  logic [3:0] tok;
  logic [4:0] tok_cnt;
  logic [AW-1:0] i1, i2, wa;
  logic [WIDTH-1:0] a, b, alu, q, dvd, dvs, rem, wd;
  logic [WIDTH:0] shl, diff;
  logic [CW-1:0] cnt;
  logic neg, fin, we;
  logic [2:0] err;
  assign rd_en = state == FETCH;
  assign busy = state != IDLE;
  assign i1 = AW'(sp - 1'b1);
  assign i2 = AW'(sp - 2'd2);
  assign a = stack[i2];
  assign b = stack[i1];
  assign alu = tok == 4'hA ? a + b : tok == 4'hB ? a - b : a * b;
  assign shl = {rem, dvd[WIDTH-1]};
  assign diff = shl - {1'b0, dvs};
  assign q = neg ? -dvd : dvd;
  assign we = (state == DECODE && err == 3'd0 && !fin && tok < 4'hD) || state == DIVWB;
  assign wa = tok < 4'hA ? AW'(sp) : i2;
  assign wd = state == DIVWB ? q : tok < 4'hA ? WIDTH'(tok) : alu;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    err = 3'd0;
    fin = 1'b0;
    case (state)
      IDLE:   state_n = start ? FETCH : IDLE;
      FETCH:  state_n = DECODE;
      DECODE: begin
        if (tok != 4'hE && tok_cnt == 5'd16) err = 3'd4;
        else if (tok < 4'hA) err = sp == SW'(DEPTH) ? 3'd2 : 3'd0;
        else if (tok < 4'hE) err = sp < SW'(2) ? 3'd1 : (tok == 4'hD && b == '0) ? 3'd3 : 3'd0;
        else if (tok == 4'hE) begin
          fin = sp == SW'(1);
          err = fin ? 3'd0 : 3'd4;
        end
        else err = 3'd4;
        state_n = (err != 3'd0 || fin) ? IDLE : tok == 4'hD ? DIVIDE : FETCH;
      end
      DIVIDE: state_n = cnt == CW'(WIDTH - 1) ? DIVWB : DIVIDE;
      DIVWB:  state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
      tok <= '0;
      tok_cnt <= '0;
      result <= '0;
      err_code <= '0;
      done <= 1'b0;
    end else begin
      done <= state == DECODE && (err != 3'd0 || fin);
      if (state == IDLE && start) begin
        sp <= '0;
        tok_cnt <= '0;
        result <= '0;
        err_code <= '0;
      end
      if (state == FETCH) begin
        tok <= queue_token;
        tok_cnt <= tok_cnt + 1'b1;
      end
      if (state == DECODE && err != 3'd0) begin
        err_code <= err;
        result <= '0;
      end
      if (fin) result <= stack[0];
      if (we) sp <= tok < 4'hA ? sp + 1'b1 : sp - 1'b1;
    end
  end
  // Divider operands are captured on every DECODE; only a D token goes on to use them.
  always_ff @(posedge clk) begin
    if (we) stack[wa] <= wd;
    if (state == DECODE) begin
      dvd <= a[WIDTH-1] ? -a : a;
      dvs <= b[WIDTH-1] ? -b : b;
      rem <= '0;
      neg <= a[WIDTH-1] ^ b[WIDTH-1];
      cnt <= '0;
    end
    if (state == DIVIDE) begin
      rem <= diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: scoreboard bench for rpn_evaluator with a modelled parser output queue
module tb_rpn_evaluator;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rewind = 1'b0;
  logic [3:0] queue_token;
  logic rd_en, busy, done;
  logic [W-1:0] result;
  logic [2:0] err_code;
  logic [3:0] q [32];
  logic [4:0] idx = '0;
  typedef struct {logic [W-1:0] res; logic [2:0] err; int reads; int lat;} exp_t;
  exp_t sb [$];
  exp_t e;
  int checks = 0, errors = 0;
  int lat, reads, bcnt, b2b = 0;
  bit armed = 0, prev_rd = 0;
  always #5 clk = ~clk;
  rpn_evaluator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .queue_token(queue_token),
    .rd_en(rd_en), .busy(busy), .done(done), .result(result), .err_code(err_code)
  );
  assign queue_token = q[idx];
  always @(posedge clk) idx <= rewind ? 5'd0 : rd_en ? idx + 5'd1 : idx;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: times each accepted evaluation and checks it against the scoreboard at done.
  always @(negedge clk) begin
    if (armed) begin
      lat++;
      if (rd_en) begin
        reads++;
        if (prev_rd) b2b++;
      end
      if (busy) bcnt++;
      if (done) begin
        armed = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %0h err %0d with empty scoreboard", result, err_code);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("err_code", err_code, e.err);
          check("rd_en_pulses", reads, e.reads);
          check("done_latency", lat, e.lat);
          check("busy_cycles", bcnt, e.lat - 1);
        end
      end
    end
    if (!rst_n) armed = 0;
    else if (start && !busy) begin
      armed = 1;
      lat = 0;
      reads = 0;
      bcnt = 0;
    end
    prev_rd = rd_en;
  end
  task automatic load(input logic [63:0] toks, input int n);
    for (int i = 0; i < 32; i++) q[i] = i < n ? toks[4*(n-1-i) +: 4] : 4'hF;
    rewind = 1'b1;
    @(posedge clk) #1 rewind = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(posedge clk) #1;
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles, expected 1 pending result", t);
      sb.delete();
    end
  endtask
  task automatic run(input logic [63:0] toks, input int n, input logic [W-1:0] res,
                     input logic [2:0] err, input int rd, input int lt);
    load(toks, n);
    sb.push_back(exp_t'{res, err, rd, lt});
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    wait_done();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) q[i] = 4'hF;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst_n = 1'b1;
    run(64'h34A2CE, 6, 16'd14, 3'd0, 6, 13);
    repeat (3) @(posedge clk);
    #1 check("result_held", result, 14);
    run(64'h27B3DE, 6, 16'hFFFF, 3'd0, 6, 30);
    run(64'h50DE, 4, 16'd0, 3'd3, 3, 7);
    run(64'hAE, 2, 16'd0, 3'd1, 1, 3);
    run(64'h34E, 3, 16'd0, 3'd4, 3, 7);
    run(64'h111111111E, 10, 16'd0, 3'd2, 9, 19);
    run(64'h99C9C9C9C9CE, 12, 16'd7153, 3'd0, 12, 25);
    run(64'h07B2DE, 6, 16'hFFFD, 3'd0, 6, 30);
    run(64'h3F, 2, 16'd0, 3'd4, 2, 5);
    run(64'h11A1A1A1A1A1A1A1, 16, 16'd0, 3'd4, 16, 33);
    run(64'h11A1A1A1A1A1A1AE, 16, 16'd8, 3'd0, 16, 33);
    load(64'h82DE, 4);
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk) #1 check_idle("mid_divide_reset");
    rst_n = 1'b1;
    load(64'h82DE, 4);
    sb.push_back(exp_t'{16'd4, 3'd0, 4, 26});
    start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    wait_done();
    check("rd_en_back_to_back", b2b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rpn_evaluator.md
# rpn_evaluator

Consumes the postfix (RPN) token queue produced by the infix-to-postfix shunting-yard parser and computes the numeric result of the expression. It drives the parser's read-enable, pops one token per fetch, and runs an operand stack with add/sub/mul in one cycle and signed division in a multicycle restoring divider. It sits between the parser's `output_queue` and the calculator's display/result register.

## Interface

Parameters:
- `WIDTH`, 16, operand/result width in bits, two's complement.
- `DEPTH`, 8, operand stack entries.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin evaluation. Accepted only in IDLE. Upstream asserts it after the parser has accepted `=` and returned to ready.
- `queue_token`  in  4  parser `output_queue`. Valid combinationally for the current read index.
- `rd_en`  out  1  parser read enable. Advances the parser read index at the clock edge.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse when evaluation ends, on success or error.
- `result`  out  WIDTH  final value. Held until the next accepted `start`.
- `err_code`  out  3  0 none, 1 stack underflow, 2 stack overflow, 3 divide by zero, 4 malformed. Held until the next accepted `start`.

## Operation

- Token encoding:
  - 0–9: digit literal.
  - A: add. B: sub. C: mul. D: div.
  - E: end of expression.
  - F: illegal in the queue.
- States: IDLE, FETCH, DECODE, DIVIDE, DIVWB.
- IDLE:
  - `start` clears `sp`, the token counter, `result` and `err_code`, then goes to FETCH.
  - `start` is ignored in every other state.
- FETCH:
  - `rd_en`=1 for exactly this cycle.
  - `queue_token` is latched into the token register at the same edge.
  - Token counter increments.
  - Next state is DECODE.
- DECODE:
  - Digit:
    - `sp`==DEPTH → error 2.
    - Otherwise push the zero-extended digit, `sp`+1, → FETCH.
  - A/B/C:
    - `sp`<2 → error 1.
    - Otherwise `stack[sp-2] <= stack[sp-2] op stack[sp-1]`, `sp`−1, → FETCH.
    - Left operand is the deeper entry.
    - Results wrap modulo 2^WIDTH. Mul keeps the low WIDTH bits.
  - D:
    - `sp`<2 → error 1.
    - Divisor `stack[sp-1]`==0 → error 3.
    - Otherwise → DIVIDE.
  - E:
    - `sp`==1 → `result <= stack[0]`, `done`, → IDLE.
    - Otherwise → error 4.
  - F → error 4.
  - Any non-E token whose token counter reached 16 → error 4 (runaway queue).
- DIVIDE:
  - Restoring divide on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Then → DIVWB.
- DIVWB:
  - Apply sign (quotient negative iff operand signs differ); the quotient truncates toward zero.
  - Most-negative / −1 wraps to most-negative.
  - Write to `stack[sp-2]`, `sp`−1, → FETCH.
- Error:
  - Latch `err_code`, force `result`=0, pulse `done`, → IDLE.
  - No further `rd_en`.
  - Resynchronising the parser is upstream's job, via its clear token.

## Timing

- Reset values: `rd_en`=0, `busy`=0, `done`=0, `result`=0, `err_code`=0, state IDLE, `sp`=0.
- `start` sampled at edge N → FETCH in cycle N+1, with `rd_en` high in cycle N+1.
- Digit, A, B, C each take 2 cycles (FETCH+DECODE). D takes WIDTH+3 cycles.
- `rd_en` pulses are never back-to-back; there is at least one DECODE cycle between them.
- `done` and final `result`/`err_code` become valid in the first IDLE cycle after terminal DECODE. A `start` in that same cycle is accepted.
- Example: expression with n tokens, no division → `done` at cycle 2n+1 after the `start` edge.
- `rst_n` low at any edge (including mid-DIVIDE or mid-FETCH):
  - Next cycle is IDLE with all outputs at reset values.
  - A partially read queue is not rewound.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Test plan

- Queue "3 4 A 2 C E", `start` → exactly 6 `rd_en` pulses, `done` at cycle 13, `result`=14, `err_code`=0.
- Queue "2 7 B 3 D E" → `result`=0xFFFF (−5/3 = −1), `err_code`=0; `busy` high for 2+2+2+2+19+2 = 29 cycles.
- Queue "5 0 D E" → `err_code`=3, `result`=0, `done` after 3 `rd_en` pulses, no 4th pulse.
- Queue "A E" → `err_code`=1 after 1 read. Queue "3 4 E" → `err_code`=4. Nine digits then E with DEPTH=8 → `err_code`=2 on the 9th read.
- Queue "8 2 D E" with `rst_n` pulled low during DIVIDE → `busy`/`done`/`result`=0 next cycle. Then reload "8 2 D E", `start` → `result`=4. `start` pulsed while busy → ignored, no extra `rd_en`.
